// File: rtl/tree_loader_if.sv
// Bundles the handshake and SRAM write ports of tree_loader into one interface.
// The master modport is the control and stream source. It drives start, node_count, s_data and s_valid.
// The slave modport is the loader. It drives s_ready, both SRAM write ports, busy, done and err.
interface tree_loader_if #(
  parameter int ADDR_WIDTH  = 6,
  parameter int COEFF_WIDTH = 48,
  parameter int CHILD_WIDTH = 18
);
  logic                   start;
  logic [6:0]             node_count;
  logic [7:0]             s_data;
  logic                   s_valid;
  logic                   s_ready;
  logic                   coeff_we;
  logic [ADDR_WIDTH-1:0]  coeff_addr;
  logic [COEFF_WIDTH-1:0] coeff_wdata;
  logic                   child_we;
  logic [ADDR_WIDTH-1:0]  child_addr;
  logic [CHILD_WIDTH-1:0] child_wdata;
  logic                   busy;
  logic                   done;
  logic                   err;

  modport master (
    output start, node_count, s_data, s_valid,
    input  s_ready, coeff_we, coeff_addr, coeff_wdata,
           child_we, child_addr, child_wdata, busy, done, err
  );

  modport slave (
    input  start, node_count, s_data, s_valid,
    output s_ready, coeff_we, coeff_addr, coeff_wdata,
           child_we, child_addr, child_wdata, busy, done, err
  );
endinterface

// File: rtl/tree_loader.sv
// Purpose: loads a decision tree from a byte stream into the coefficient and child SRAMs.
//   A node is 9 bytes, most significant byte first.
// Latency: each node is written in the cycle after its 9th byte. done follows the last write by 1 cycle.
//   Throughput is 10 cycles per node.
// Backpressure: s_ready is high only while collecting bytes. A low s_valid stalls indefinitely.
// Ports: clk and rst (asynchronous, active high).
//   bus.slave carries start/node_count, the s_* byte stream, the coeff_* and child_* SRAM write ports,
//   and the busy/done/err status.
module tree_loader #(
  parameter int ADDR_WIDTH  = 6,
  parameter int DEPTH       = 64,
  parameter int COEFF_WIDTH = 48,
  parameter int CHILD_WIDTH = 18
) (
  input logic         clk,
  input logic         rst,
  tree_loader_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, FIN} state_t;

  localparam logic [6:0] DEPTH_CNT = 7'(DEPTH);

  state_t                 state;
  logic [6:0]             count;
  logic [ADDR_WIDTH-1:0]  node_idx;
  logic [3:0]             byte_idx;
  // Assembly registers are kept separate from the wdata outputs so that the outputs
  // hold the last written word while the next node streams in.
  logic [COEFF_WIDTH-1:0] coeff_asm;
  logic [CHILD_WIDTH-9:0] child_hi;

  logic legal_count;
  logic take;
  logic last_node;

  assign legal_count = (bus.node_count != 7'd0) && (bus.node_count <= DEPTH_CNT);
  assign take        = bus.s_valid && bus.s_ready;
  assign last_node   = (7'(node_idx) == (count - 7'd1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      count           <= '0;
      node_idx        <= '0;
      byte_idx        <= '0;
      coeff_asm       <= '0;
      child_hi        <= '0;
      bus.s_ready     <= 1'b0;
      bus.coeff_we    <= 1'b0;
      bus.coeff_addr  <= '0;
      bus.coeff_wdata <= '0;
      bus.child_we    <= 1'b0;
      bus.child_addr  <= '0;
      bus.child_wdata <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.err         <= 1'b0;
    end else begin
      // Strobes are single-cycle. They fall back to 0 unless this cycle re-asserts them.
      bus.coeff_we <= 1'b0;
      bus.child_we <= 1'b0;
      bus.done     <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.start) begin
            bus.busy <= 1'b1;
            if (legal_count) begin
              bus.err     <= 1'b0;
              count       <= bus.node_count;
              node_idx    <= '0;
              byte_idx    <= '0;
              bus.s_ready <= 1'b1;
              state       <= LOAD;
            end else begin
              // A bad count skips straight to the completion pulse and writes nothing.
              bus.err  <= 1'b1;
              bus.done <= 1'b1;
              state    <= FIN;
            end
          end
        end

        LOAD: begin
          if (take) begin
            byte_idx <= byte_idx + 4'd1;
            case (byte_idx)
              4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5: begin
                coeff_asm <= {coeff_asm[COEFF_WIDTH-9:0], bus.s_data};
              end
              4'd6: begin
                // Only the two low bits carry child data. Other set bits are flagged and dropped.
                child_hi[9:8] <= bus.s_data[1:0];
                if (bus.s_data[7:2] != 6'd0) begin
                  bus.err <= 1'b1;
                end
              end
              4'd7: begin
                child_hi[7:0] <= bus.s_data;
              end
              4'd8: begin
                bus.s_ready     <= 1'b0;
                bus.coeff_we    <= 1'b1;
                bus.child_we    <= 1'b1;
                bus.coeff_addr  <= node_idx;
                bus.child_addr  <= node_idx;
                bus.coeff_wdata <= coeff_asm;
                bus.child_wdata <= {child_hi, bus.s_data};
                state           <= WRITE;
              end
              default: begin
              end
            endcase
          end
        end

        WRITE: begin
          if (last_node) begin
            bus.done <= 1'b1;
            state    <= FIN;
          end else begin
            node_idx    <= node_idx + 1'b1;
            byte_idx    <= '0;
            bus.s_ready <= 1'b1;
            state       <= LOAD;
          end
        end

        FIN: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tree_loader.sv
module tb_tree_loader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tree_loader_if #(.ADDR_WIDTH(6), .COEFF_WIDTH(48), .CHILD_WIDTH(18)) bus ();

  tree_loader #(.ADDR_WIDTH(6), .DEPTH(64), .COEFF_WIDTH(48), .CHILD_WIDTH(18)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [5:0]  addr;
    logic [47:0] coeff;
    logic [17:0] child;
  } wr_t;

  typedef struct {
    logic err;
    int   total;  // expected cycles from first byte to done; 0 = not checked
  } dn_t;

  wr_t exp_wr[$];
  dn_t exp_dn[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Synthetic node data; byte 6 is masked so that it carries no format error.
  function automatic logic [7:0] nb(input int k, input int j);
    logic [7:0] b;
    b = 8'((k * 9 + j) * 7 + 3);
    if (j == 6) b = b & 8'h03;
    return b;
  endfunction

  task automatic expect_node(input int addr, input int k);
    logic [7:0] b [9];
    wr_t w;
    for (int j = 0; j < 9; j++) b[j] = nb(k, j);
    w.addr  = 6'(addr);
    w.coeff = {b[0], b[1], b[2], b[3], b[4], b[5]};
    w.child = {b[6][1:0], b[7], b[8]};
    exp_wr.push_back(w);
  endtask

  // ---------------- monitor / scoreboard ----------------
  int cyc = 0;
  int first_cyc = -1;
  int last_wr = -1;

  always @(negedge clk) begin
    if (rst) begin
      first_cyc = -1;
      last_wr   = -1;
    end else begin
      cyc++;
      if (bus.s_valid && bus.s_ready && first_cyc < 0) first_cyc = cyc;
      if (bus.coeff_we || bus.child_we) begin
        wr_t w;
        chk("coeff_we", 64'(bus.coeff_we), 64'd1);
        chk("child_we", 64'(bus.child_we), 64'd1);
        if (exp_wr.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: got addr %0d expected no write", bus.coeff_addr);
        end else begin
          w = exp_wr.pop_front();
          chk("coeff_addr",  64'(bus.coeff_addr),  64'(w.addr));
          chk("child_addr",  64'(bus.child_addr),  64'(w.addr));
          chk("coeff_wdata", 64'(bus.coeff_wdata), 64'(w.coeff));
          chk("child_wdata", 64'(bus.child_wdata), 64'(w.child));
        end
        last_wr = cyc;
      end
      if (bus.done) begin
        dn_t d;
        if (exp_dn.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got done=1 expected 0");
        end else begin
          d = exp_dn.pop_front();
          chk("done_err", 64'(bus.err), 64'(d.err));
          chk("done_busy", 64'(bus.busy), 64'd1);
          if (last_wr >= 0) chk("write_to_done", 64'(cyc - last_wr), 64'd1);
          if (d.total > 0) chk("first_byte_to_done", 64'(cyc - first_cyc), 64'(d.total));
        end
        first_cyc = -1;
        last_wr   = -1;
      end
    end
  end

  // ---------------- stimulus helpers (all return at posedge+1) ----------------
  task automatic do_start(input logic [6:0] n);
    bus.node_count = n;
    bus.start      = 1'b1;
    @(posedge clk); #1;
    bus.start      = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stall);
    bit ok = 1'b0;
    if (stall) begin
      int k = $urandom_range(0, 3);
      bus.s_valid = 1'b0;
      repeat (k) begin @(posedge clk); #1; end
    end
    bus.s_data  = b;
    bus.s_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (bus.s_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
      end
    end
    bus.s_valid = 1'b0;
    chk("byte_accept", 64'(ok), 64'd1);
  endtask

  task automatic send_node(input int k, input int nbytes, input bit stall);
    for (int j = 0; j < nbytes; j++) send_byte(nb(k, j), stall);
  endtask

  task automatic wait_done(input int limit);
    bit seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    @(posedge clk); #1;
    chk("done_seen", 64'(seen), 64'd1);
    chk("done_one_cycle", 64'(bus.done), 64'd0);
    chk("idle_busy", 64'(bus.busy), 64'd0);
    chk("wr_queue_empty", 64'(exp_wr.size()), 64'd0);
    chk("dn_queue_empty", 64'(exp_dn.size()), 64'd0);
  endtask

  task automatic run_load(input int n, input int seed, input bit stall, input int total, input bit mid_start);
    for (int a = 0; a < n; a++) expect_node(a, seed + a);
    exp_dn.push_back('{err: 1'b0, total: total});
    do_start(7'(n));
    for (int a = 0; a < n; a++) begin
      send_node(seed + a, 9, stall);
      if (mid_start && a == 1) begin
        // One pulse lands in WRITE and one in LOAD; the loader must ignore both.
        do_start(7'd2);
        do_start(7'd0);
      end
    end
    wait_done(n * 40 + 50);
  endtask

  task automatic run_vec(input logic [7:0] v [9], input logic [47:0] coeff,
                         input logic [17:0] child, input logic err_exp);
    exp_wr.push_back('{addr: 6'd0, coeff: coeff, child: child});
    exp_dn.push_back('{err: err_exp, total: 10});
    do_start(7'd1);
    for (int j = 0; j < 9; j++) send_byte(v[j], 1'b0);
    wait_done(50);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_s_ready"},     64'(bus.s_ready),     64'd0);
    chk({tag, "_coeff_we"},    64'(bus.coeff_we),    64'd0);
    chk({tag, "_child_we"},    64'(bus.child_we),    64'd0);
    chk({tag, "_busy"},        64'(bus.busy),        64'd0);
    chk({tag, "_done"},        64'(bus.done),        64'd0);
    chk({tag, "_err"},         64'(bus.err),         64'd0);
    chk({tag, "_coeff_addr"},  64'(bus.coeff_addr),  64'd0);
    chk({tag, "_child_addr"},  64'(bus.child_addr),  64'd0);
    chk({tag, "_coeff_wdata"}, 64'(bus.coeff_wdata), 64'd0);
    chk({tag, "_child_wdata"}, 64'(bus.child_wdata), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  logic [7:0] vec_basic [9];
  logic [7:0] vec_fmt [9];

  initial begin
    vec_basic = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h01, 8'h23, 8'h45};
    vec_fmt   = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'hFD, 8'h67, 8'h89};
    bus.start      = 1'b0;
    bus.node_count = 7'd0;
    bus.s_data     = 8'h00;
    bus.s_valid    = 1'b0;
    rst            = 1'b1;
    #1;
    chk_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Illegal count 0: err set, no writes, one done pulse.
    exp_dn.push_back('{err: 1'b1, total: 0});
    do_start(7'd0);
    wait_done(20);
    chk("err_sticky_cnt0", 64'(bus.err), 64'd1);

    // Single node; a legal start also clears the sticky err.
    run_vec(vec_basic, 48'h112233445566, 18'h12345, 1'b0);
    chk("err_after_single", 64'(bus.err), 64'd0);

    // Illegal count 65.
    exp_dn.push_back('{err: 1'b1, total: 0});
    do_start(7'd65);
    wait_done(20);
    chk("err_sticky_cnt65", 64'(bus.err), 64'd1);

    // Format error in byte 6 (0xFD -> child bits 17:16 = 01).
    run_vec(vec_fmt, 48'hAABBCCDDEEFF, 18'h16789, 1'b1);

    // Full tree, back to back.
    run_load(64, 0, 1'b0, 640, 1'b0);

    // Four nodes unstalled, then the same data with random stalls and a start pulse mid-load.
    run_load(4, 200, 1'b0, 40, 1'b0);
    run_load(4, 200, 1'b1, 0, 1'b1);

    // Reset after byte 4 of node 2: only nodes 0 and 1 are ever written.
    expect_node(0, 300);
    expect_node(1, 300 + 1);
    do_start(7'd4);
    send_node(300, 9, 1'b0);
    send_node(301, 9, 1'b0);
    send_node(302, 5, 1'b0);
    chk("busy_before_rst", 64'(bus.busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk_reset_outputs("midload_rst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_wr_queue_empty", 64'(exp_wr.size()), 64'd0);
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_idle_busy", 64'(bus.busy), 64'd0);

    // A fresh load after the reset writes from address 0.
    run_vec(vec_basic, 48'h112233445566, 18'h12345, 1'b0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
